// File: rtl/npc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : npc_seq                                                    |
// | Description : Multi-cycle NPC sequencer. Owns PC and instruction         |
// |               register and steps each instruction through fetch,         |
// |               execute, optional memory access and write-back using       |
// |               valid/ready handshakes to a variable-latency IFU and LSU.  |
// |               Decode, ALU and register file stay external.               |
// | Ports       : clk/rst (async active-high reset)                          |
// |               ifu_*   : fetch request/response handshake                 |
// |               dec_*, imm, alu_result : combinational decode/ALU inputs   |
// |               lsu_*   : memory request/response handshake                |
// |               pc, snpc, dnpc, inst : datapath outputs to IDU/ALU         |
// |               reg_we, commit, halt : retire strobes and sticky halt      |
// | Options     : NPC_PERF_CNT_EN adds perf_cycle / perf_instret counters    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module npc_seq #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_resp_valid,
  input  logic [31:0]     ifu_inst,
  output logic [31:0]     inst,
  input  logic [1:0]      dec_npc_sel,
  input  logic            dec_mem_ren,
  input  logic            dec_mem_wen,
  input  logic            dec_reg_wen,
  input  logic            dec_halt,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_resp_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic [XLEN-1:0] dnpc,
  output logic            reg_we,
  output logic            commit,
  output logic            halt
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;

  logic            w_inst_ld;
  logic            w_ifu_req_valid;
  logic            w_lsu_req_valid;
  logic            w_commit;
  logic            w_reg_we;
  logic            w_halt;
  logic [XLEN-1:0] w_snpc;
  logic [XLEN-1:0] w_dnpc;
  logic [XLEN-1:0] w_npc;

  // PC arithmetic wraps naturally at XLEN bits.
  assign w_snpc = r_pc + XLEN'(4);
  assign w_dnpc = r_pc + imm;

  always_comb begin
    w_npc = w_snpc;
    case (dec_npc_sel)
      2'b00:   w_npc = w_snpc;
      2'b01:   w_npc = w_dnpc;
      2'b10:   w_npc = {alu_result[XLEN-1:1], 1'b0};
      2'b11:   w_npc = alu_result[0] ? w_dnpc : w_snpc;
      default: w_npc = w_snpc;
    endcase
  end

  // Next-state and handshake/strobe outputs. Response strobes are only
  // consulted in their own wait states, so stray pulses elsewhere (including
  // late responses to transactions abandoned by reset) have no effect.
  always_comb begin
    w_state_nxt     = r_state;
    w_inst_ld       = 1'b0;
    w_ifu_req_valid = 1'b0;
    w_lsu_req_valid = 1'b0;
    w_commit        = 1'b0;
    w_reg_we        = 1'b0;
    w_halt          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IF_REQ;
      end
      S_IF_REQ: begin
        w_ifu_req_valid = 1'b1;
        if (ifu_req_ready) w_state_nxt = S_IF_WAIT;
      end
      S_IF_WAIT: begin
        if (ifu_resp_valid) begin
          w_inst_ld   = 1'b1;
          w_state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (dec_halt)                        w_state_nxt = S_HALT;
        else if (dec_mem_ren || dec_mem_wen) w_state_nxt = S_MEM_REQ;
        else                                 w_state_nxt = S_WB;
      end
      S_MEM_REQ: begin
        w_lsu_req_valid = 1'b1;
        if (lsu_req_ready) w_state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) w_state_nxt = S_WB;
      end
      S_WB: begin
        w_commit    = 1'b1;
        w_reg_we    = dec_reg_wen;
        w_state_nxt = S_IF_REQ;
      end
      S_HALT: begin
        w_halt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_VECTOR;
      r_inst  <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      if (w_inst_ld) r_inst <= ifu_inst;
      if (w_commit)  r_pc   <= w_npc;
    end
  end

`ifdef NPC_PERF_CNT_EN
  logic [63:0] r_perf_cycle;
  logic [63:0] r_perf_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycle   <= 64'd0;
      r_perf_instret <= 64'd0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) r_perf_cycle <= r_perf_cycle + 64'd1;
      if (w_commit) r_perf_instret <= r_perf_instret + 64'd1;
    end
  end

  assign perf_cycle   = r_perf_cycle;
  assign perf_instret = r_perf_instret;
`endif

  assign ifu_req_valid = w_ifu_req_valid;
  assign ifu_addr      = r_pc;
  assign inst          = r_inst;
  assign lsu_req_valid = w_lsu_req_valid;
  assign pc            = r_pc;
  assign snpc          = w_snpc;
  assign dnpc          = w_dnpc;
  assign reg_we        = w_reg_we;
  assign commit        = w_commit;
  assign halt          = w_halt;

endmodule
`default_nettype wire

// File: tb/tb_npc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_npc_seq                                                 |
// | Description : Self-checking bench for npc_seq. Acts as IFU, LSU and      |
// |               decoder; a cycle-level reference of the instruction        |
// |               lifecycle and a next-PC model give every expected value.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_npc_seq;
  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_inst, inst;
  logic [1:0]  dec_npc_sel;
  logic        dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_halt;
  logic [31:0] imm, alu_result;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] pc, snpc, dnpc;
  logic        reg_we, commit, halt;
`ifdef NPC_PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  npc_seq #(.XLEN(32), .RESET_VECTOR(RV), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_inst(ifu_inst), .inst(inst),
    .dec_npc_sel(dec_npc_sel), .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
    .dec_reg_wen(dec_reg_wen), .dec_halt(dec_halt), .imm(imm), .alu_result(alu_result),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
    .pc(pc), .snpc(snpc), .dnpc(dnpc), .reg_we(reg_we), .commit(commit), .halt(halt)
`ifdef NPC_PERF_CNT_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  // Handshake rule: once a request is raised it must stay up until ready.
  logic p_ifv, p_ifr, p_lsv, p_lsr;
  always @(posedge clk) begin
    p_ifv <= ifu_req_valid;
    p_ifr <= ifu_req_ready;
    p_lsv <= lsu_req_valid;
    p_lsr <= lsu_req_ready;
  end
  always @(negedge clk) begin
    if (rst === 1'b0 && p_ifv === 1'b1 && p_ifr === 1'b0) begin
      checks++;
      if (ifu_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL ifu_valid_hold: got %b want 1", ifu_req_valid);
      end
    end
    if (rst === 1'b0 && p_lsv === 1'b1 && p_lsr === 1'b0) begin
      checks++;
      if (lsu_req_valid !== 1'b1) begin
        errors++;
        $display("FAIL lsu_valid_hold: got %b want 1", lsu_req_valid);
      end
    end
  end

  // Next-PC reference computed in 64-bit space and reduced modulo 2^32.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] sel,
                                          input logic [31:0] imm_v, input logic [31:0] alu_v);
    longint unsigned p, i, a, s, d, r;
    p = cur; i = imm_v; a = alu_v;
    s = (p + 4) % 64'h1_0000_0000;
    d = (p + i) % 64'h1_0000_0000;
    case (sel)
      2'd0:    r = s;
      2'd1:    r = d;
      2'd2:    r = a - (a % 2);
      default: r = (a % 2 == 1) ? d : s;
    endcase
    return r[31:0];
  endfunction

  // Drives one instruction from its first IF_REQ cycle to WB (or into HALT),
  // checking every cycle's control outputs against the expected phase.
  task automatic run_inst(input logic [1:0] sel, input bit ren, input bit wen, input bit rwen,
                          input bit hlt, input logic [31:0] imm_v, input logic [31:0] alu_v,
                          input logic [31:0] word, input int d_ifr, input int d_ifp,
                          input int d_lr, input int d_lp, input bit stray_if, input bit stray_ls);
    logic [4:0] obs;
    logic [4:0] exp_wb;
    for (int k = 0; k <= d_ifr; k++) begin
      @(negedge clk);
      obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
      checks++;
      if (obs !== 5'b10000) begin
        errors++; $display("FAIL if_req_ctrl: got %b want 10000", obs);
      end
      if (k == 0) begin
        checks++;
        if (ifu_addr !== m_pc || pc !== m_pc) begin
          errors++; $display("FAIL fetch_addr: got %h/%h want %h", ifu_addr, pc, m_pc);
        end
        checks++;
        if (inst !== m_inst) begin
          errors++; $display("FAIL inst_hold: got %h want %h", inst, m_inst);
        end
        dec_npc_sel = sel; dec_mem_ren = ren; dec_mem_wen = wen;
        dec_reg_wen = rwen; dec_halt = hlt; imm = imm_v; alu_result = alu_v;
      end
      lsu_resp_valid = 1'b0;
      ifu_req_ready  = (k == d_ifr);
      ifu_resp_valid = stray_if;
      ifu_inst       = ~word;
    end
    for (int k = 0; k <= d_ifp; k++) begin
      @(negedge clk);
      obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
      checks++;
      if (obs !== 5'b00000) begin
        errors++; $display("FAIL if_wait_ctrl: got %b want 00000", obs);
      end
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = (k == d_ifp);
      ifu_inst       = (k == d_ifp) ? word : ~word;
    end
    // EX
    @(negedge clk);
    obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL ex_ctrl: got %b want 00000", obs);
    end
    checks++;
    if (inst !== word) begin
      errors++; $display("FAIL inst_latch: got %h want %h", inst, word);
    end
    checks++;
    if (snpc !== m_pc + 32'd4 || dnpc !== m_pc + imm_v) begin
      errors++; $display("FAIL npc_cand: got %h/%h want %h/%h", snpc, dnpc, m_pc + 32'd4, m_pc + imm_v);
    end
    m_inst = word;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = stray_ls;
    if (hlt) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
        checks++;
        if (obs !== 5'b00001 || pc !== m_pc) begin
          errors++; $display("FAIL halt_state: got %b pc %h want 00001 pc %h", obs, pc, m_pc);
        end
        ifu_req_ready  = 1'b1;
        lsu_req_ready  = 1'b1;
        lsu_resp_valid = k[0];
        ifu_resp_valid = ~k[0];
      end
      ifu_req_ready = 1'b0; lsu_req_ready = 1'b0;
      lsu_resp_valid = 1'b0; ifu_resp_valid = 1'b0;
      return;
    end
    if (ren || wen) begin
      for (int k = 0; k <= d_lr; k++) begin
        @(negedge clk);
        obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
        checks++;
        if (obs !== 5'b01000) begin
          errors++; $display("FAIL mem_req_ctrl: got %b want 01000", obs);
        end
        lsu_resp_valid = 1'b0;
        lsu_req_ready  = (k == d_lr);
      end
      for (int k = 0; k <= d_lp; k++) begin
        @(negedge clk);
        obs = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
        checks++;
        if (obs !== 5'b00000) begin
          errors++; $display("FAIL mem_wait_ctrl: got %b want 00000", obs);
        end
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = (k == d_lp);
      end
    end
    // WB
    @(negedge clk);
    obs    = {ifu_req_valid, lsu_req_valid, commit, reg_we, halt};
    exp_wb = {2'b00, 1'b1, rwen, 1'b0};
    checks++;
    if (obs !== exp_wb) begin
      errors++; $display("FAIL wb_ctrl: got %b want %b", obs, exp_wb);
    end
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = stray_ls;
    m_pc = ref_npc(m_pc, sel, imm_v, alu_v);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_inst = 32'h0;
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    dec_npc_sel = 2'b00; dec_mem_ren = 1'b0; dec_mem_wen = 1'b0;
    dec_reg_wen = 1'b0; dec_halt = 1'b0; imm = 32'h0; alu_result = 32'h0;
    #1;
    checks++;
    if ({ifu_req_valid, lsu_req_valid, commit, reg_we, halt} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000",
                         {ifu_req_valid, lsu_req_valid, commit, reg_we, halt});
    end
    checks++;
    if (pc !== RV || ifu_addr !== RV || inst !== NOP) begin
      errors++; $display("FAIL reset_regs: got pc %h inst %h want %h %h", pc, inst, RV, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc = RV; m_inst = NOP;
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid: got %b want 0", ifu_req_valid);
    end
  endtask

  task automatic test_first_fetch();
    run_inst(2'b00, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_0093, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fetch_stall();
    run_inst(2'b00, 0, 0, 0, 0, 32'h4, 32'h0, 32'h1234_5013, 3, 2, 0, 0, 1, 0);
  endtask

  task automatic test_branch();
    run_inst(2'b11, 0, 0, 0, 0, 32'h10, 32'h1, 32'h0000_0463, 0, 0, 0, 0, 0, 0);
    run_inst(2'b11, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0000_0463, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jalr();
    run_inst(2'b10, 0, 0, 1, 0, 32'h0, 32'h8000_0101, 32'h0000_00e7, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_load_store();
    run_inst(2'b00, 1, 0, 1, 0, 32'h8, 32'h8000_1000, 32'h0081_2083, 0, 0, 2, 3, 0, 1);
    run_inst(2'b00, 0, 1, 0, 0, 32'hC, 32'h8000_2000, 32'h0011_2623, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    run_inst(2'b10, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFD, 32'h0000_0067, 0, 0, 0, 0, 0, 0);
    run_inst(2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0013, 0, 0, 0, 0, 0, 0);
    run_inst(2'b01, 0, 0, 0, 0, 32'h8000_0000, 32'h0, 32'h0000_006f, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] sel;
    int kind;
    bit rwen;
    for (int n = 0; n < 40; n++) begin
      sel  = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 2);
      rwen = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      run_inst(sel, kind == 1, kind == 2, rwen, 0, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_halt();
    run_inst(2'b00, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0010_0073, 1, 1, 0, 0, 0, 1);
  endtask

  // Reset arrives while a fetch is outstanding; its late response must be dropped.
  task automatic test_reset_ifwait();
    @(negedge clk);
    dec_npc_sel = 2'b00; dec_halt = 1'b0; dec_mem_ren = 1'b0; dec_mem_wen = 1'b0;
    lsu_resp_valid = 1'b0;
    checks++;
    if (ifu_req_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_req: got %b want 1", ifu_req_valid);
    end
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== RV || inst !== NOP || ifu_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ifwait: got pc %h inst %h v %b want %h %h 0",
                         pc, inst, ifu_req_valid, RV, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_inst = 32'hDEAD_BEEF;
    m_pc = RV; m_inst = NOP;
    run_inst(2'b00, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0020_0093, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fetch_stall();
    test_branch();
    test_reset();
    test_branch();
    test_jalr();
    test_load_store();
    test_wrap();
    test_random();
    test_halt();
    test_reset();
    test_first_fetch();
    test_reset_ifwait();
    test_first_fetch();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
